// File: rtl/blowfish128_stream_adapter.sv
// -----------------------------------------------------------------------------
// blowfish128_stream_adapter
//
// Word-serial front/back end for the Blowfish-128 engine. Four 32-bit input
// words (first word = bits [127:96]) are packed into one block, the engine is
// launched and awaited, and the 128-bit result is returned as four 32-bit
// output words in the same order. Input and output blocks never overlap.
//
// Optional feature macro: BLOWFISH128_CBC_EN (CBC chaining plus iv_load/iv).
//
// Parameters:
//   ENG_TIMEOUT    max RUN cycles to wait for eng_ready (10-bit counter)
// Ports:
//   Clk, RstN      clock, synchronous active-low reset
//   Encrypt        direction, sampled with the first word of a block
//   in_data/in_valid/in_ready     input word stream
//   out_data/out_valid/out_ready  output word stream
//   eng_enable     engine start (level, high for the whole RUN state)
//   eng_encrypt    direction forwarded to the engine
//   eng_plaintext  block presented to the engine
//   eng_ciphertext engine result, qualified by eng_ready
//   busy           adapter is not idle
//   timeout_err    sticky engine-timeout flag, cleared only by reset
//   iv_load, iv    (CBC build only) chain register load, accepted in IDLE
// -----------------------------------------------------------------------------
module blowfish128_stream_adapter #(
    parameter int ENG_TIMEOUT = 1023
) (
    input  logic         Clk,
    input  logic         RstN,
    input  logic         Encrypt,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [31:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         eng_enable,
    output logic         eng_encrypt,
    output logic [127:0] eng_plaintext,
    input  logic [127:0] eng_ciphertext,
    input  logic         eng_ready,
    output logic         busy,
`ifdef BLOWFISH128_CBC_EN
    input  logic         iv_load,
    input  logic [127:0] iv,
`endif
    output logic         timeout_err
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_e;

    localparam logic [9:0] WAIT_LAST = 10'(ENG_TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [127:0]  blk_q, blk_d;      // input block under assembly
    logic [1:0]    cnt_q, cnt_d;      // words accepted so far
    logic          enc_q, enc_d;
    logic [9:0]    wait_q, wait_d;    // RUN cycles elapsed
    logic [127:0]  res_q, res_d;      // output buffer
    logic [1:0]    idx_q, idx_d;      // output word index
    logic [127:0]  pt_q, pt_d;
    logic          tmo_q, tmo_d;
`ifdef BLOWFISH128_CBC_EN
    logic [127:0]  chain_q, chain_d;
`endif

    logic in_hs;
    logic out_hs;

    // An IV load in IDLE takes priority, so the word is refused that cycle.
    always_comb begin
        in_ready = RstN && ((state_q == IDLE) || (state_q == LOAD));
`ifdef BLOWFISH128_CBC_EN
        if ((state_q == IDLE) && iv_load) begin
            in_ready = 1'b0;
        end
`endif
    end

    assign out_valid     = (state_q == DRAIN);
    assign eng_enable    = (state_q == RUN);
    assign busy          = (state_q != IDLE);
    assign eng_encrypt   = enc_q;
    assign eng_plaintext = pt_q;
    assign timeout_err   = tmo_q;
    assign in_hs         = in_valid && in_ready;
    assign out_hs        = out_valid && out_ready;

    always_comb begin
        case (idx_q)
            2'd0:    out_data = res_q[127:96];
            2'd1:    out_data = res_q[95:64];
            2'd2:    out_data = res_q[63:32];
            default: out_data = res_q[31:0];
        endcase
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path
        // through the case statement can leave one unassigned (no latches).
        state_d = state_q;
        blk_d   = blk_q;
        cnt_d   = cnt_q;
        enc_d   = enc_q;
        wait_d  = wait_q;
        res_d   = res_q;
        idx_d   = idx_q;
        pt_d    = pt_q;
        tmo_d   = tmo_q;
`ifdef BLOWFISH128_CBC_EN
        chain_d = chain_q;
`endif

        // Word slot chosen by count keeps w0 in the MSBs.
        if (in_hs) begin
            case (cnt_q)
                2'd0:    blk_d[127:96] = in_data;
                2'd1:    blk_d[95:64]  = in_data;
                2'd2:    blk_d[63:32]  = in_data;
                default: blk_d[31:0]   = in_data;
            endcase
        end

        case (state_q)
            IDLE: begin
`ifdef BLOWFISH128_CBC_EN
                if (iv_load) begin
                    chain_d = iv;
                end
`endif
                if (in_hs) begin
                    enc_d   = Encrypt;
                    cnt_d   = 2'd1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (in_hs) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        pt_d = blk_d;
`ifdef BLOWFISH128_CBC_EN
                        if (enc_q) begin
                            pt_d = blk_d ^ chain_q;
                        end
`endif
                        wait_d  = 10'd0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // A result on the last allowed cycle still wins over timeout.
                if (eng_ready) begin
                    res_d = eng_ciphertext;
`ifdef BLOWFISH128_CBC_EN
                    if (enc_q) begin
                        chain_d = eng_ciphertext;
                    end else begin
                        res_d   = eng_ciphertext ^ chain_q;
                        chain_d = blk_q;
                    end
`endif
                    idx_d   = 2'd0;
                    state_d = DRAIN;
                end else if (wait_q == WAIT_LAST) begin
                    tmo_d   = 1'b1;
                    cnt_d   = 2'd0;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 10'd1;
                end
            end
            DRAIN: begin
                if (out_hs) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!RstN) begin
            state_q <= IDLE;
            blk_q   <= '0;
            cnt_q   <= '0;
            enc_q   <= 1'b0;
            wait_q  <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            pt_q    <= '0;
            tmo_q   <= 1'b0;
`ifdef BLOWFISH128_CBC_EN
            chain_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational block.
            state_q <= state_d;
            blk_q   <= blk_d;
            cnt_q   <= cnt_d;
            enc_q   <= enc_d;
            wait_q  <= wait_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            pt_q    <= pt_d;
            tmo_q   <= tmo_d;
`ifdef BLOWFISH128_CBC_EN
            chain_q <= chain_d;
`endif
        end
    end

endmodule

// File: tb/tb_blowfish128_stream_adapter.sv
// -----------------------------------------------------------------------------
// tb_blowfish128_stream_adapter
//
// Bench for blowfish128_stream_adapter with an engine stub that returns
// eng_plaintext ^ {16{8'hA5}} and raises eng_ready 5 cycles after eng_enable
// rises (or never, when stub_hang is set). The DUT runs with ENG_TIMEOUT = 20.
// Define BLOWFISH128_CBC_EN to exercise the CBC build as well.
// -----------------------------------------------------------------------------
module tb_blowfish128_stream_adapter;

    localparam int           TMO = 20;
    localparam logic [127:0] KEY = {16{8'hA5}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         encrypt;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         eng_enable;
    logic         eng_encrypt;
    logic [127:0] eng_plaintext;
    logic [127:0] eng_ciphertext;
    logic         eng_ready;
    logic         busy;
    logic         timeout_err;
`ifdef BLOWFISH128_CBC_EN
    logic         iv_load;
    logic [127:0] iv;
`endif

    always #5 clk = ~clk;

    blowfish128_stream_adapter #(.ENG_TIMEOUT(TMO)) dut (
        .Clk            (clk),
        .RstN           (rst_n),
        .Encrypt        (encrypt),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .eng_enable     (eng_enable),
        .eng_encrypt    (eng_encrypt),
        .eng_plaintext  (eng_plaintext),
        .eng_ciphertext (eng_ciphertext),
        .eng_ready      (eng_ready),
        .busy           (busy),
`ifdef BLOWFISH128_CBC_EN
        .iv_load        (iv_load),
        .iv             (iv),
`endif
        .timeout_err    (timeout_err)
    );

    // Engine stub
    logic [2:0] stub_cnt = 3'd0;
    logic       stub_hang;
    always @(posedge clk) begin
        if (!eng_enable)           stub_cnt <= 3'd0;
        else if (stub_cnt != 3'd7) stub_cnt <= stub_cnt + 3'd1;
    end
    assign eng_ready      = eng_enable && !stub_hang && (stub_cnt == 3'd5);
    assign eng_ciphertext = eng_plaintext ^ KEY;

    // Monitors, sampled on the falling edge
    int           en_cycles = 0;
    bit           ov_seen   = 1'b0;
    logic         prev_en   = 1'b0;
    logic [127:0] pt_log[$];
    logic         enc_log[$];
    always @(negedge clk) begin
        if (eng_enable) en_cycles++;
        if (out_valid)  ov_seen = 1'b1;
        if (eng_enable && !prev_en) begin
            pt_log.push_back(eng_plaintext);
            enc_log.push_back(eng_encrypt);
        end
        prev_en = eng_enable;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: whole-block arithmetic on the packed 128-bit value.
`ifdef BLOWFISH128_CBC_EN
    logic [127:0] m_chain = '0;
`endif
    function automatic logic [127:0] model(input logic [127:0] blk, input logic enc);
        logic [127:0] r;
`ifdef BLOWFISH128_CBC_EN
        if (enc) begin
            r = (blk ^ m_chain) ^ KEY;
            m_chain = r;
        end else begin
            r = (blk ^ KEY) ^ m_chain;
            m_chain = blk;
        end
`else
        r = blk ^ KEY;
        if (enc) r = r;
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
`ifdef BLOWFISH128_CBC_EN
        m_chain = '0;
`endif
    endtask

    task automatic send_word(input logic [31:0] w, input logic enc);
        int b = 0;
        in_valid = 1'b1;
        in_data  = w;
        encrypt  = enc;
        while (!in_ready && b < 50) begin
            tick();
            b++;
        end
        if (!in_ready) check("in_ready_wait", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    // Encrypt is flipped after the first word; only the first must count.
    task automatic send_block(input logic [127:0] blk, input logic enc);
        send_word(blk[127:96], enc);
        send_word(blk[95:64], ~enc);
        send_word(blk[63:32], ~enc);
        send_word(blk[31:0], ~enc);
    endtask

    // mode 0: out_ready held high; mode 1: out_ready toggles 0/1.
    task automatic recv_block(output logic [127:0] res, input int mode);
        int          got = 0;
        int          cyc = 0;
        logic        ph = 1'b0;
        logic        stalled = 1'b0;
        logic [31:0] held = '0;
        res = '0;
        while (got < 4 && cyc < 100) begin
            out_ready = (mode == 0) ? 1'b1 : ph;
            ph = ~ph;
            #1;
            if (out_valid) begin
                if (stalled) check("stall_hold", out_data, held);
                check("in_ready_drain", in_ready, 0);
                if (out_ready) begin
                    res[127 - 32*got -: 32] = out_data;
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = out_data;
                end
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        if (got < 4) check("recv_wait", got, 4);
    endtask

    typedef struct {
        logic [127:0] blk;
        logic         enc;
        logic [127:0] exp;
    } vec_t;

    vec_t         tbl[4];
    logic [127:0] res;
    logic [127:0] blk;
    logic [127:0] exp;
    logic         enc;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        encrypt   = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        stub_hang = 1'b0;
`ifdef BLOWFISH128_CBC_EN
        iv_load   = 1'b0;
        iv        = '0;
`endif
        tbl[0] = '{128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1,
                   128'hA5B48796_E1F0C3D2_2D3C0F1E_69784B5A};
        tbl[1] = '{128'h0, 1'b0, {4{32'hA5A5A5A5}}};
        tbl[2] = '{{4{32'hFFFFFFFF}}, 1'b1, {4{32'h5A5A5A5A}}};
        tbl[3] = '{128'hDEADBEEF_12345678_00000000_FFFFFFFF, 1'b0,
                   128'h7B081B4A_B791F3DD_A5A5A5A5_5A5A5A5A};

        // Reset values
        tick();
        check("rst_in_ready",    in_ready, 0);
        check("rst_out_valid",   out_valid, 0);
        check("rst_eng_enable",  eng_enable, 0);
        check("rst_eng_encrypt", eng_encrypt, 0);
        check("rst_plaintext",   eng_plaintext, 0);
        check("rst_out_data",    out_data, 0);
        check("rst_busy",        busy, 0);
        check("rst_timeout",     timeout_err, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Table-driven blocks
        for (int i = 0; i < 4; i++) begin
            do_reset();
            pt_log.delete();
            enc_log.delete();
            en_cycles = 0;
            send_block(tbl[i].blk, tbl[i].enc);
            check("tbl_launch", eng_enable, 1);
            recv_block(res, 0);
            check("tbl_out", res, tbl[i].exp);
            check("tbl_busy_done", busy, 0);
            check("tbl_in_ready_done", in_ready, 1);
            check("tbl_en_cycles", en_cycles, 6);
            check("tbl_plaintext", pt_log[0], tbl[i].blk);
            check("tbl_encrypt", enc_log[0], tbl[i].enc);
        end

        // Output backpressure
        do_reset();
        send_block(tbl[0].blk, 1'b1);
        recv_block(res, 1);
        check("bp_out", res, tbl[0].exp);
        check("bp_in_ready_done", in_ready, 1);

        // Gapped input with garbage on in_data while in_valid is low
        do_reset();
        pt_log.delete();
        send_word(32'h00112233, 1'b1);
        send_word(32'h44556677, 1'b1);
        in_data = 32'hDEADDEAD;
        for (int i = 0; i < 3; i++) tick();
        send_word(32'h8899AABB, 1'b1);
        send_word(32'hCCDDEEFF, 1'b1);
        recv_block(res, 0);
        check("gap_plaintext", pt_log[0], 128'h00112233_44556677_8899AABB_CCDDEEFF);
        check("gap_out", res, tbl[0].exp);

        // Randomized blocks against the reference model
        do_reset();
        for (int i = 0; i < 8; i++) begin
            blk = {$urandom, $urandom, $urandom, $urandom};
            enc = 1'($urandom_range(0, 1));
            exp = model(blk, enc);
            send_block(blk, enc);
            recv_block(res, int'($urandom_range(0, 1)));
            check("rand_out", res, exp);
        end

        // Engine timeout, then a normal block with the flag still set
        do_reset();
        stub_hang = 1'b1;
        en_cycles = 0;
        ov_seen   = 1'b0;
        send_block(tbl[0].blk, 1'b1);
        begin
            int b = 0;
            while (busy && b < 100) begin
                tick();
                b++;
            end
        end
        check("tmo_err", timeout_err, 1);
        check("tmo_run_cycles", en_cycles, TMO);
        check("tmo_no_out_valid", ov_seen, 0);
        check("tmo_idle", busy, 0);
        check("tmo_in_ready", in_ready, 1);
        stub_hang = 1'b0;
        exp = model(tbl[2].blk, 1'b1);
        send_block(tbl[2].blk, 1'b1);
        recv_block(res, 0);
        check("tmo_next_out", res, exp);
        check("tmo_sticky", timeout_err, 1);

        // Reset after two output words
        send_block(tbl[0].blk, 1'b1);
        begin
            int b = 0;
            while (!out_valid && b < 50) begin
                tick();
                b++;
            end
        end
        check("mid_out_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        check("mid_rst_out_valid",  out_valid, 0);
        check("mid_rst_enable",     eng_enable, 0);
        check("mid_rst_encrypt",    eng_encrypt, 0);
        check("mid_rst_plaintext",  eng_plaintext, 0);
        check("mid_rst_out_data",   out_data, 0);
        check("mid_rst_busy",       busy, 0);
        check("mid_rst_timeout",    timeout_err, 0);
        check("mid_rst_in_ready",   in_ready, 0);
        rst_n = 1'b1;
        #1;
`ifdef BLOWFISH128_CBC_EN
        m_chain = '0;
`endif
        check("mid_post_in_ready", in_ready, 1);
        ov_seen = 1'b0;
        tick();
        tick();
        check("mid_no_output", ov_seen, 0);
        send_block(tbl[3].blk, 1'b0);
        recv_block(res, 0);
        check("mid_next_out", res, tbl[3].exp);

`ifdef BLOWFISH128_CBC_EN
        // CBC chaining with IV = 1
        do_reset();
        iv_load  = 1'b1;
        iv       = 128'h1;
        in_valid = 1'b1;
        in_data  = 32'h12345678;
        #1;
        check("cbc_iv_wins", in_ready, 0);
        tick();
        iv_load  = 1'b0;
        in_valid = 1'b0;
        pt_log.delete();
        blk = tbl[0].blk;
        send_block(blk, 1'b1);
        recv_block(res, 0);
        exp = res;
        check("cbc_first_out", res, blk ^ 128'h1 ^ KEY);
        send_block(blk, 1'b1);
        recv_block(res, 0);
        check("cbc_first_pt", pt_log[0], blk ^ 128'h1);
        check("cbc_second_pt", pt_log[1], blk ^ exp);
        check("cbc_second_out", res, blk ^ exp ^ KEY);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
